// File: rtl/mult_control_if.sv
// ---------------------------------------------------------------------------
// mult_control_if
// Bundles the handshake between the shift-add multiplier datapath and its
// controller.
//   start : request a new multiplication          (datapath/host -> controller)
//   k     : bit counter terminal count            (datapath -> controller)
//   m     : current multiplier LSB                (datapath -> controller)
//   load  : load operands, clear bit counter      (controller -> datapath)
//   ad    : add multiplicand into upper half      (controller -> datapath)
//   sh    : shift product/multiplier right        (controller -> datapath)
//   busy  : operation in progress                 (controller -> host)
//   done  : product valid                         (controller -> host)
// The master modport is the datapath/host side; the slave is the controller.
// ---------------------------------------------------------------------------
interface mult_control_if;
  logic start;
  logic k;
  logic m;
  logic load;
  logic ad;
  logic sh;
  logic busy;
  logic done;

  modport master (
    output start, k, m,
    input  load, ad, sh, busy, done
  );

  modport slave (
    input  start, k, m,
    output load, ad, sh, busy, done
  );
endinterface

// File: rtl/mult_control.sv
// ---------------------------------------------------------------------------
// mult_control
// Moore controller for a shift-add multiplier.
//   Clk   : system clock, all state changes on the rising edge
//   Reset : asynchronous, active-high reset (forces IDLE immediately)
//   Abort : optional, present only when MULT_CONTROL_ABORT_EN is defined;
//           drops any running operation back to IDLE without Done
//   bus   : mult_control_if.slave (start/k/m in, load/ad/sh/busy/done out)
// Parameter DONE_CYCLES (1..15) sets how many cycles Done stays high.
// Optional feature macro: MULT_CONTROL_ABORT_EN.
// ---------------------------------------------------------------------------
module mult_control #(
  parameter int DONE_CYCLES = 1
) (
  input  logic           Clk,
  input  logic           Reset,
`ifdef MULT_CONTROL_ABORT_EN
  input  logic           Abort,
`endif
  mult_control_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    CHECK = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Hold counter value on the final DONE cycle.
  localparam logic [3:0] HOLD_LAST = 4'(DONE_CYCLES - 1);

  state_t     state_reg, state_next;
  logic [3:0] hold_reg,  hold_next;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg <= IDLE;
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    hold_next  = '0;
    case (state_reg)
      IDLE:  if (bus.start) state_next = INIT;
      INIT:  state_next = CHECK;
      CHECK: state_next = bus.m ? ADD : SHIFT;
      ADD:   state_next = SHIFT;
      SHIFT: state_next = bus.k ? DONE : CHECK;
      DONE: begin
        if (hold_reg == HOLD_LAST) begin
          state_next = IDLE;
        end else begin
          hold_next = hold_reg + 4'd1;
        end
      end
      // Encodings 6 and 7 are never entered normally; recover to IDLE.
      default: state_next = IDLE;
    endcase
`ifdef MULT_CONTROL_ABORT_EN
    // Abort overrides every transition, including SHIFT -> DONE, so an
    // aborted operation can never raise Done.
    if (Abort && (state_reg != IDLE)) begin
      state_next = IDLE;
      hold_next  = '0;
    end
`endif
  end

  // Pure Moore decode: each strobe belongs to exactly one state, which keeps
  // load/ad/sh mutually exclusive by construction.
  assign bus.load = (state_reg == INIT);
  assign bus.ad   = (state_reg == ADD);
  assign bus.sh   = (state_reg == SHIFT);
  assign bus.done = (state_reg == DONE);
  assign bus.busy = (state_reg != IDLE);

endmodule

// File: tb/tb_mult_control.sv
// ---------------------------------------------------------------------------
// tb_mult_control
// Two controllers (DONE_CYCLES = 1 and 3) share the same input stimulus.
// A table of vectors covers Start held high, then a trace-level reference
// model (expected output sequence built from the multiplier word) checks
// directed words, reset/abort sequences and random traffic.
// Output vectors are packed as {load, ad, sh, busy, done}.
// ---------------------------------------------------------------------------
module tb_mult_control;

  logic Clk;
  logic Reset;
  logic abort_drv;

  mult_control_if bus1 ();
  mult_control_if bus3 ();

  assign bus3.start = bus1.start;
  assign bus3.m     = bus1.m;
  assign bus3.k     = bus1.k;

  mult_control #(.DONE_CYCLES(1)) dut1 (
    .Clk   (Clk),
    .Reset (Reset),
`ifdef MULT_CONTROL_ABORT_EN
    .Abort (abort_drv),
`endif
    .bus   (bus1)
  );

  mult_control #(.DONE_CYCLES(3)) dut3 (
    .Clk   (Clk),
    .Reset (Reset),
`ifdef MULT_CONTROL_ABORT_EN
    .Abort (abort_drv),
`endif
    .bus   (bus3)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [4:0] outs1();
    return {bus1.load, bus1.ad, bus1.sh, bus1.busy, bus1.done};
  endfunction

  function automatic logic [4:0] outs3();
    return {bus3.load, bus3.ad, bus3.sh, bus3.busy, bus3.done};
  endfunction

  // ---------------- reference model ----------------
  // One entry per clock cycle: expected outputs plus the m/k values the
  // emulated datapath presents during that cycle.
  typedef struct packed {
    logic [4:0] exp;
    logic       m;
    logic       k;
  } ent_t;

  ent_t q1[$];
  ent_t q3[$];
  ent_t cur1, cur3;

  function automatic ent_t mk(input logic [4:0] e, input logic m, input logic k);
    ent_t r;
    r.exp = e;
    r.m   = m;
    r.k   = k;
    return r;
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic ent_t idle_ent();
    return mk(5'b00000, rb(), rb());
  endfunction

  // Expected trace of one operation: Load, then per multiplier bit a
  // decision cycle (M presented), an add when the bit is 1, a shift (K
  // presented on the last bit), then Done for dc cycles.
  task automatic push_op(input int which, input logic [31:0] bits, input int nbits, input int dc);
    ent_t tr[$];
    tr.push_back(mk(5'b10010, rb(), rb()));
    for (int i = 0; i < nbits; i++) begin
      tr.push_back(mk(5'b00010, bits[i], rb()));
      if (bits[i]) tr.push_back(mk(5'b01010, rb(), rb()));
      tr.push_back(mk(5'b00110, rb(), (i == nbits - 1)));
    end
    for (int i = 0; i < dc; i++) tr.push_back(mk(5'b00011, rb(), rb()));
    foreach (tr[i]) begin
      if (which == 1) q1.push_back(tr[i]);
      else            q3.push_back(tr[i]);
    end
  endtask

  // Drive one cycle of inputs (called at a falling edge), advance the model
  // on the rising edge and compare both DUTs at the next falling edge.
  task automatic tick(input logic s, input logic [31:0] bits, input int nbits, input logic ab);
    logic idle1, idle3;
    idle1      = !cur1.exp[1];
    idle3      = !cur3.exp[1];
    bus1.start = s;
    bus1.m     = cur1.m;
    bus1.k     = cur1.k;
    abort_drv  = ab;
    @(posedge Clk);
`ifdef MULT_CONTROL_ABORT_EN
    if (ab && !idle1) q1.delete();
    if (ab && !idle3) q3.delete();
`endif
    if (s && idle1) push_op(1, bits, nbits, 1);
    if (s && idle3) push_op(3, bits, nbits, 3);
    cur1 = (q1.size() > 0) ? q1.pop_front() : idle_ent();
    cur3 = (q3.size() > 0) ? q3.pop_front() : idle_ent();
    @(negedge Clk);
    chk("model_dc1", 32'(outs1()), 32'(cur1.exp));
    chk("model_dc3", 32'(outs3()), 32'(cur3.exp));
  endtask

  // Run one whole operation and tally its strobes on both DUTs.
  task automatic run_word(input string name, input logic [31:0] bits, input int nbits,
                          input logic poke, input int e_busy1, input int e_ad, input int e_sh);
    int busy1 = 0, busy3 = 0, ad1 = 0, sh1 = 0, ld1 = 0, dn1 = 0, dn3 = 0, ovl = 0;
    int c;
    tick(1'b1, bits, nbits, 1'b0);
    c = 0;
    while (c < 300) begin
      busy1 += int'(bus1.busy);
      busy3 += int'(bus3.busy);
      ad1   += int'(bus1.ad);
      sh1   += int'(bus1.sh);
      ld1   += int'(bus1.load);
      dn1   += int'(bus1.done);
      dn3   += int'(bus3.done);
      if (int'(bus1.load) + int'(bus1.ad) + int'(bus1.sh) > 1) ovl++;
      if (!bus1.busy && !bus3.busy) break;
      tick(poke && bus1.busy && bus3.busy, $urandom, 3, 1'b0);
      c++;
    end
    chk({name, "_timeout"}, 32'(c >= 300), 32'd0);
    chk({name, "_busy_dc1"}, 32'(busy1), 32'(e_busy1));
    chk({name, "_busy_dc3"}, 32'(busy3), 32'(e_busy1 + 2));
    chk({name, "_ad"},       32'(ad1),   32'(e_ad));
    chk({name, "_sh"},       32'(sh1),   32'(e_sh));
    chk({name, "_load"},     32'(ld1),   32'd1);
    chk({name, "_done_dc1"}, 32'(dn1),   32'd1);
    chk({name, "_done_dc3"}, 32'(dn3),   32'd3);
    chk({name, "_overlap"},  32'(ovl),   32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       start;
    logic       m;
    logic       k;
    logic [4:0] exp1;
    logic [4:0] exp3;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic ab;
    Reset      = 1'b1;
    bus1.start = 1'b0;
    bus1.m     = 1'b0;
    bus1.k     = 1'b0;
    abort_drv  = 1'b0;

    // Start held high with M=0, K=1: one-bit operations back to back.
    // K is already high while CHECK is active and must be ignored there.
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 5'b10010, 5'b10010};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 5'b00010, 5'b00010};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 5'b00110, 5'b00110};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 5'b00011, 5'b00011};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 5'b00000, 5'b00011};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 5'b10010, 5'b00011};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 5'b00010, 5'b00000};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 5'b00110, 5'b10010};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 5'b00011, 5'b00010};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 5'b00000, 5'b00110};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 5'b00000, 5'b00011};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 5'b00000, 5'b00011};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 5'b00000, 5'b00011};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 5'b00000, 5'b00000};

    @(negedge Clk);
    @(negedge Clk);
    chk("reset_dc1", 32'(outs1()), 32'd0);
    chk("reset_dc3", 32'(outs3()), 32'd0);
    Reset = 1'b0;

    // Idle with Start low must stay idle.
    @(negedge Clk);
    chk("idle_hold", 32'(outs1()), 32'd0);

    for (int i = 0; i < 14; i++) begin
      bus1.start = tbl[i].start;
      bus1.m     = tbl[i].m;
      bus1.k     = tbl[i].k;
      @(negedge Clk);
      chk($sformatf("tbl%0d_dc1", i), 32'(outs1()), 32'(tbl[i].exp1));
      chk($sformatf("tbl%0d_dc3", i), 32'(outs3()), 32'(tbl[i].exp3));
    end

    cur1 = idle_ent();
    cur3 = idle_ent();

    // 32-bit words: all zeros and all ones, then Start poked while busy.
    run_word("zeros32", 32'h0000_0000, 32, 1'b0, 66, 0, 32);
    tick(1'b0, 32'd0, 1, 1'b0);
    run_word("ones32",  32'hFFFF_FFFF, 32, 1'b0, 98, 32, 32);
    tick(1'b0, 32'd0, 1, 1'b0);
    run_word("poke",    32'h0000_0005, 3,  1'b1, 1 + 2 * 3 + 2 + 1, 2, 3);
    tick(1'b0, 32'd0, 1, 1'b0);

    // Asynchronous reset in the middle of an ADD cycle.
    tick(1'b1, 32'h0000_0001, 4, 1'b0);
    tick(1'b0, 32'd0, 1, 1'b0);
    tick(1'b0, 32'd0, 1, 1'b0);
    chk("in_add", 32'(bus1.ad), 32'd1);
    Reset = 1'b1;
    #1;
    chk("async_rst_dc1", 32'(outs1()), 32'd0);
    chk("async_rst_dc3", 32'(outs3()), 32'd0);
    @(posedge Clk);
    @(negedge Clk);
    chk("rst_held", 32'(outs1() | outs3()), 32'd0);
    Reset = 1'b0;
    q1.delete();
    q3.delete();
    cur1 = idle_ent();
    cur3 = idle_ent();
    tick(1'b0, 32'd0, 1, 1'b0);
    tick(1'b1, 32'h0000_0002, 2, 1'b0);
    chk("restart_load", 32'(bus1.load), 32'd1);
    for (int i = 0; i < 20; i++) tick(1'b0, 32'd0, 1, 1'b0);

`ifdef MULT_CONTROL_ABORT_EN
    // Abort coinciding with the final SHIFT while K=1.
    tick(1'b1, 32'd0, 1, 1'b0);
    tick(1'b0, 32'd0, 1, 1'b0);
    tick(1'b0, 32'd0, 1, 1'b0);
    chk("abort_in_shift", 32'(bus1.sh), 32'd1);
    tick(1'b0, 32'd0, 1, 1'b1);
    chk("abort_done", 32'(bus1.done | bus3.done), 32'd0);
    chk("abort_idle", 32'(bus1.busy | bus3.busy), 32'd0);
    tick(1'b0, 32'd0, 1, 1'b0);
`endif

    // Random traffic; Start only when both DUTs agree on idle/busy so the
    // shared M/K drive stays meaningful for both.
    for (int i = 0; i < 1500; i++) begin
      logic both_idle, both_busy, s;
      both_idle = !cur1.exp[1] && !cur3.exp[1];
      both_busy =  cur1.exp[1] &&  cur3.exp[1];
      s  = (both_idle || both_busy) ? ($urandom_range(0, 2) == 0) : 1'b0;
      ab = 1'b0;
`ifdef MULT_CONTROL_ABORT_EN
      ab = ($urandom_range(0, 40) == 0);
`endif
      tick(s, $urandom, $urandom_range(1, 8), ab);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_control.md
MULT_CONTROL -- requirements
Module: mult_control

Interface
REQ-001 Parameter DONE_CYCLES, default 1, number of consecutive cycles Done is held high, legal range 1-15.
REQ-002 Clk  input  1  system clock; all state changes on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Start  input  1  request a new multiplication; sampled only in IDLE.
REQ-005 K  input  1  terminal-count flag from the multiplier bit counter; high means the last bit is being processed.
REQ-006 M  input  1  current multiplier LSB from the product/multiplier shift register.
REQ-007 Load  output  1  loads operands into the datapath and clears the bit counter.
REQ-008 Ad  output  1  adds the multiplicand into the upper product half.
REQ-009 Sh  output  1  shifts the product/multiplier register right by one.
REQ-010 Busy  output  1  high in every state except IDLE.
REQ-011 Done  output  1  product valid in the datapath.

Function
REQ-012 Controller SHALL be a Moore FSM with states IDLE, INIT, CHECK, ADD, SHIFT and DONE.
REQ-013 All outputs SHALL be decoded from the state register only; no combinational input-to-output path.
REQ-014 IDLE SHALL go to INIT on the rising edge where Start=1; otherwise it SHALL stay in IDLE.
REQ-015 INIT SHALL assert Load for exactly one cycle, then go to CHECK.
REQ-016 CHECK SHALL go to ADD if M=1 and to SHIFT if M=0; no outputs asserted.
REQ-017 ADD SHALL assert Ad for exactly one cycle, then go to SHIFT.
REQ-018 SHIFT SHALL assert Sh for exactly one cycle.
REQ-019 SHIFT SHALL go to DONE if K=1 at that edge, else to CHECK.
REQ-020 DONE SHALL assert Done for DONE_CYCLES consecutive cycles using an internal 4-bit hold counter, then go to IDLE.
REQ-021 Load, Ad and Sh SHALL be mutually exclusive in every cycle.
REQ-022 Start asserted outside IDLE SHALL be ignored, including during DONE; no request is queued.
REQ-023 Start held high continuously SHALL begin a new operation on the first cycle back in IDLE; back-to-back operations are separated by exactly one IDLE cycle.
REQ-024 Busy SHALL be high from the INIT cycle through the last DONE cycle inclusive.
REQ-025 The operation latency in cycles SHALL be 1 (INIT) + 2×(bits) + (number of 1 bits in the multiplier) + DONE_CYCLES.
REQ-026 K=1 seen outside SHIFT SHALL have no effect.
REQ-027 Unused state encodings SHALL return to IDLE on the next edge.

Reset
REQ-028 Reset=1 SHALL force IDLE immediately, regardless of Clk.
REQ-029 During reset, Load, Ad, Sh, Busy and Done SHALL be 0 and the hold counter SHALL be 0.
REQ-030 Reset mid-operation SHALL abandon the operation without asserting Done.
REQ-031 After Reset deasserts, the first transition SHALL occur on the first rising edge with Start=1.

Configuration
REQ-032 With macro MULT_CONTROL_ABORT_EN defined, an input port Abort (1 bit) SHALL exist.
REQ-033 With the macro, Abort=1 at a rising edge in any non-IDLE state SHALL move the FSM to IDLE next cycle with Done never asserted for that operation.
REQ-034 With the macro, Abort SHALL take priority over every other transition, including SHIFT to DONE.
REQ-035 Without the macro, the Abort port SHALL be absent and behaviour SHALL be as in REQ-014 to REQ-027.

Verification
REQ-036 Multiplier bits all 0 (M=0 always), K pulsed on the 32nd SHIFT, Start pulsed 1 cycle -> Load 1 cycle, 32 Sh pulses, 0 Ad, Done 1 cycle, total Busy 66 cycles.
REQ-037 M=1 always, same K -> 32 Ad each immediately followed by Sh, Busy 98 cycles, Ad/Sh/Load never overlap.
REQ-038 DONE_CYCLES=3, Start held high -> Done high 3 cycles, one IDLE cycle, then Load again.
REQ-039 Reset asserted asynchronously mid-ADD -> all outputs 0 before the next edge, no Done; a new Start restarts at INIT.
REQ-040 Start pulsed while Busy=1 -> ignored, only one Done produced.
REQ-041 With MULT_CONTROL_ABORT_EN, Abort=1 in the same cycle as the final SHIFT with K=1 -> IDLE next cycle, Done stays 0.
